// File: rtl/result_uart_sender.sv
// Result RAM readout streamer: walks every result RAM address-major, RAM-minor,
// and serialises each 32-bit word to the UART transmitter as 4 bytes, MSB first.
// Each byte is paced on a rising edge of the transmitter's tx_done.
//
// Handshake: o_uart_send_data is a one-cycle request, and o_uart_tx_data is valid
// in that cycle. The next request is issued only after a rising edge of
// i_uart_tx_done has been seen in a later cycle than the request.
module result_uart_sender #(
    parameter int N      = 2,
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 2
) (
    input  logic                 i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_num_words,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic [N*N-1:0]      o_ram_rden,
    input  logic [N*N*32-1:0]   i_ram_q,
    output logic [7:0]          o_uart_tx_data,
    output logic                o_uart_send_data,
    input  logic                i_uart_tx_done,
    output logic                o_busy,
    output logic                o_done,
    output logic [2:0]          o_dbg_state
);

    localparam int NK = N * N;
    localparam int KW = (NK > 1) ? $clog2(NK) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_TX = 3'd4,
        S_NEXT    = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_num_words;
    logic [ADDR_W-1:0]   r_addr;
    logic [KW-1:0]       r_k;
    logic [CW-1:0]       r_wait;
    logic [1:0]          r_byte_cnt;
    logic [31:0]         r_shift;
    logic                r_tx_done_d;
    logic [NK-1:0]       r_ram_rden;
    logic                r_send;
    logic                r_busy;
    logic                r_done;

    logic [31:0]         w_word;
    logic                w_tx_edge;

    // RAM k's word is selected by the current RAM index.
    assign w_word    = i_ram_q[int'(r_k) * 32 +: 32];
    // Only a low-to-high transition counts, so a level held across bytes is not re-counted.
    assign w_tx_edge = i_uart_tx_done & ~r_tx_done_d;

    // Readout sequencer; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_num_words <= '0;
            r_addr      <= '0;
            r_k         <= '0;
            r_wait      <= '0;
            r_byte_cnt  <= '0;
            r_shift     <= '0;
            r_tx_done_d <= 1'b0;
            r_ram_rden  <= '0;
            r_send      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_tx_done_d <= i_uart_tx_done;
            r_send      <= 1'b0;
            r_done      <= 1'b0;
            r_ram_rden  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_words <= i_num_words;
                        r_busy      <= 1'b1;
                        r_addr      <= '0;
                        r_k         <= '0;
                        if (i_num_words == '0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_ram_rden <= NK'(1);
                            r_state    <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_wait  <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // The last wait cycle is the one in which ram_q is valid.
                    if (r_wait == CW'(RD_LAT - 1)) begin
                        r_shift    <= w_word;
                        r_byte_cnt <= '0;
                        r_send     <= 1'b1;
                        r_state    <= S_SEND;
                    end else begin
                        r_wait <= r_wait + CW'(1);
                    end
                end
                S_SEND: begin
                    // A tx_done edge here belongs to an earlier frame and is dropped.
                    r_state <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (w_tx_edge) begin
                        if (r_byte_cnt != 2'd3) begin
                            r_shift    <= {r_shift[23:0], 8'h00};
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                            r_send     <= 1'b1;
                            r_state    <= S_SEND;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_k != KW'(NK - 1)) begin
                        r_k        <= r_k + KW'(1);
                        r_ram_rden <= NK'(1) << (r_k + KW'(1));
                        r_state    <= S_RD_REQ;
                    end else if (r_addr != r_num_words - ADDR_W'(1)) begin
                        r_k        <= '0;
                        r_addr     <= r_addr + ADDR_W'(1);
                        r_ram_rden <= NK'(1);
                        r_state    <= S_RD_REQ;
                    end else begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ram_addr       = r_addr;
    assign o_ram_rden       = r_ram_rden;
    assign o_uart_tx_data   = r_shift[31:24];
    assign o_uart_send_data = r_send;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_dbg_state      = r_state;

endmodule
